// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Bundles the request and status signals between the instruction decoder /
//   datapath and the program-counter sequencer.
//   master modport : decoder side, drives requests, observes PC and status.
//   slave modport  : pc_sequencer side, consumes requests, drives PC and status.
//   Request signals : stall, exception, jr, jr_target, jump, jump_index,
//                     branch_taken, branch_offset, halt_req, resume.
//   Status signals  : pc, pc_plus4, epc, fetch_valid, state.
//   With PC_SEQ_PERF_CNT_EN defined, retired_cnt and stall_cnt are added.
interface pc_sequencer_if #(
   parameter int N_BIT = 32
);
   logic             stall;
   logic             exception;
   logic             jr;
   logic [N_BIT-1:0] jr_target;
   logic             jump;
   logic [25:0]      jump_index;
   logic             branch_taken;
   logic [N_BIT-1:0] branch_offset;
   logic             halt_req;
   logic             resume;

   logic [N_BIT-1:0] pc;
   logic [N_BIT-1:0] pc_plus4;
   logic [N_BIT-1:0] epc;
   logic             fetch_valid;
   logic [1:0]       state;
`ifdef PC_SEQ_PERF_CNT_EN
   logic [31:0]      retired_cnt;
   logic [31:0]      stall_cnt;
`endif

   modport master (
      output stall, exception, jr, jr_target, jump, jump_index,
             branch_taken, branch_offset, halt_req, resume,
      input  pc, pc_plus4, epc, fetch_valid, state
`ifdef PC_SEQ_PERF_CNT_EN
      , input retired_cnt, stall_cnt
`endif
   );

   modport slave (
      input  stall, exception, jr, jr_target, jump, jump_index,
             branch_taken, branch_offset, halt_req, resume,
      output pc, pc_plus4, epc, fetch_valid, state
`ifdef PC_SEQ_PERF_CNT_EN
      , output retired_cnt, stall_cnt
`endif
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the MIPS program counter and selects its next value each cycle.
//   Next-PC priority in RUN: exception, stall (hold), jr, jump, taken branch,
//   halt_req (steps to PC+4 and halts), sequential PC+4.
//   After reset a BOOT phase of BOOT_CYCLES edges holds RESET_VECTOR before the
//   first fetch; HALT holds the PC until resume or an exception.
//   Ports:
//     clk      - system clock, rising edge
//     reset_n  - asynchronous active-low reset
//     bus      - pc_sequencer_if.slave (requests in; pc, pc_plus4, epc,
//                fetch_valid, state out)
//   Optional: define PC_SEQ_PERF_CNT_EN to add retired_cnt / stall_cnt.
module pc_sequencer #(
   parameter int               N_BIT        = 32,
   parameter logic [N_BIT-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [N_BIT-1:0] EXC_VECTOR   = 32'h8000_0180,
   parameter int               BOOT_CYCLES  = 2
) (
   input logic          clk,
   input logic          reset_n,
   pc_sequencer_if.slave bus
);

   localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10
   } state_t;

   state_t            state_reg, state_next;
   logic [N_BIT-1:0]  pc_reg, pc_next;
   logic [N_BIT-1:0]  epc_reg, epc_next;
   logic [CNT_W-1:0]  boot_cnt_reg, boot_cnt_next;

   logic [N_BIT-1:0]  pc_plus4;
   logic [N_BIT-1:0]  branch_target;
   logic [N_BIT-1:0]  jump_target;
   logic [N_BIT-1:0]  jr_target_aligned;

   assign pc_plus4          = pc_reg + N_BIT'(4);
   assign branch_target     = pc_plus4 + (bus.branch_offset << 2);
   // J-type target keeps the 256 MB region of the delay-slot address.
   assign jump_target       = {pc_plus4[N_BIT-1 -: 4], bus.jump_index, 2'b00};
   // Misaligned jr targets are silently aligned, no trap is raised.
   assign jr_target_aligned = {bus.jr_target[N_BIT-1:2], 2'b00};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_BOOT;
         pc_reg       <= RESET_VECTOR;
         epc_reg      <= '0;
         boot_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         epc_reg      <= epc_next;
         boot_cnt_reg <= boot_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      epc_next      = epc_reg;
      boot_cnt_next = boot_cnt_reg;

      case (state_reg)
         ST_BOOT: begin
            // Requests are ignored until the boot wait has elapsed.
            pc_next = RESET_VECTOR;
            if (boot_cnt_reg == BOOT_LAST) begin
               state_next    = ST_RUN;
               boot_cnt_next = '0;
            end else begin
               boot_cnt_next = boot_cnt_reg + CNT_W'(1);
            end
         end

         ST_RUN: begin
            if (bus.exception) begin
               // Exception overrides a stall.
               pc_next  = EXC_VECTOR;
               epc_next = pc_reg;
            end else if (bus.stall) begin
               // Lower-priority requests are dropped, not queued.
               pc_next = pc_reg;
            end else if (bus.jr) begin
               pc_next = jr_target_aligned;
            end else if (bus.jump) begin
               pc_next = jump_target;
            end else if (bus.branch_taken) begin
               pc_next = branch_target;
            end else if (bus.halt_req) begin
               // Step past the halting instruction so resume continues after it.
               pc_next    = pc_plus4;
               state_next = ST_HALT;
            end else begin
               pc_next = pc_plus4;
            end
         end

         ST_HALT: begin
            if (bus.exception) begin
               pc_next    = EXC_VECTOR;
               epc_next   = pc_reg;
               state_next = ST_RUN;
            end else if (bus.resume) begin
               state_next = ST_RUN;
            end
         end

         default: begin
            // Encoding 11 cannot be reached normally; recover through BOOT.
            state_next    = ST_BOOT;
            pc_next       = RESET_VECTOR;
            boot_cnt_next = '0;
         end
      endcase
   end

   assign bus.pc          = pc_reg;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.epc         = epc_reg;
   assign bus.fetch_valid = (state_reg == ST_RUN);
   assign bus.state       = state_reg;

`ifdef PC_SEQ_PERF_CNT_EN
   logic [31:0] retired_cnt_reg;
   logic [31:0] stall_cnt_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         retired_cnt_reg <= '0;
         stall_cnt_reg   <= '0;
      end else if (state_reg == ST_RUN) begin
         if (bus.stall) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end else if (!bus.exception) begin
            retired_cnt_reg <= retired_cnt_reg + 32'd1;
         end
      end
   end

   assign bus.retired_cnt = retired_cnt_reg;
   assign bus.stall_cnt   = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Scoreboard bench for pc_sequencer: the stimulus process drives one request
//   set per cycle, advances an abstract reference model and queues the
//   expected post-edge status; a monitor pops and compares after every edge.
module tb_pc_sequencer;

   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam logic [31:0] EXCV = 32'h8000_0180;
   localparam int          BOOT = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic [1:0]  st;
      logic [31:0] ret;
      logic [31:0] stc;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   int   txn;
   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: mode 0 = boot, 1 = run, 2 = halt.
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   int          m_mode;
   int          m_boot_left;
   logic [31:0] m_ret;
   logic [31:0] m_stc;

   pc_sequencer_if #(.N_BIT(32)) bus ();

   pc_sequencer #(
      .N_BIT(32),
      .RESET_VECTOR(RV),
      .EXC_VECTOR(EXCV),
      .BOOT_CYCLES(BOOT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: one comparison set per edge for which an expectation is queued.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         txn++;
         $display("txn %0d pc=%h epc=%h state=%0d", txn, bus.pc, bus.epc, bus.state);
         chk("pc", bus.pc, mon_e.pc);
         chk("pc_plus4", bus.pc_plus4, mon_e.pc + 32'd4);
         chk("epc", bus.epc, mon_e.epc);
         chk("state", {30'd0, bus.state}, {30'd0, mon_e.st});
         chk("fetch_valid", {31'd0, bus.fetch_valid}, (mon_e.st == 2'd1) ? 32'd1 : 32'd0);
`ifdef PC_SEQ_PERF_CNT_EN
         chk("retired_cnt", bus.retired_cnt, mon_e.ret);
         chk("stall_cnt", bus.stall_cnt, mon_e.stc);
`endif
      end
   end

   task automatic model_reset();
      m_pc        = RV;
      m_epc       = 32'd0;
      m_mode      = 0;
      m_boot_left = BOOT;
      m_ret       = 32'd0;
      m_stc       = 32'd0;
   endtask

   // Called at a falling edge: drive, predict the next rising edge, then wait.
   task automatic step(input bit s, input bit e, input bit j_r, input logic [31:0] jt,
                       input bit j, input logic [25:0] ji, input bit b,
                       input logic [31:0] off, input bit h, input bit r);
      exp_t        x;
      logic [31:0] seq;
      bus.stall         = s;
      bus.exception     = e;
      bus.jr            = j_r;
      bus.jr_target     = jt;
      bus.jump          = j;
      bus.jump_index    = ji;
      bus.branch_taken  = b;
      bus.branch_offset = off;
      bus.halt_req      = h;
      bus.resume        = r;

      seq = m_pc + 32'd4;
      if (m_mode == 1) begin
         if (s) m_stc = m_stc + 32'd1;
         else if (!e) m_ret = m_ret + 32'd1;
      end
      case (m_mode)
         0: begin
            m_boot_left = m_boot_left - 1;
            if (m_boot_left == 0) m_mode = 1;
         end
         1: begin
            if (e) begin
               m_epc = m_pc;
               m_pc  = EXCV;
            end else if (!s) begin
               if (j_r)     m_pc = jt & 32'hFFFF_FFFC;
               else if (j)  m_pc = (seq & 32'hF000_0000) | ({6'd0, ji} * 32'd4);
               else if (b)  m_pc = seq + off * 32'd4;
               else begin
                  m_pc = seq;
                  if (h) m_mode = 2;
               end
            end
         end
         default: begin
            if (e) begin
               m_epc  = m_pc;
               m_pc   = EXCV;
               m_mode = 1;
            end else if (r) begin
               m_mode = 1;
            end
         end
      endcase
      x.pc  = m_pc;
      x.epc = m_epc;
      x.st  = 2'(m_mode);
      x.ret = m_ret;
      x.stc = m_stc;
      exp_q.push_back(x);
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 0);
   endtask

   task automatic go_jr(input logic [31:0] t);
      step(0, 0, 1, t, 0, 26'd0, 0, 32'd0, 0, 0);
   endtask

   // Called at a falling edge; asserts reset mid-cycle and checks it acts at once.
   task automatic do_reset();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_pc", bus.pc, RV);
      chk("rst_epc", bus.epc, 32'd0);
      chk("rst_state", {30'd0, bus.state}, 32'd0);
      chk("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      txn      = 0;
      reset_n  = 1'b1;
      bus.stall = 0; bus.exception = 0; bus.jr = 0; bus.jr_target = '0;
      bus.jump = 0; bus.jump_index = '0; bus.branch_taken = 0;
      bus.branch_offset = '0; bus.halt_req = 0; bus.resume = 0;

      @(negedge clk);
      do_reset();

      // Boot wait then sequential fetch 4, 8, 12.
      repeat (5) idle();

      // Branch backwards then J-type jump.
      go_jr(32'h0000_0040);
      step(0, 0, 0, 32'd0, 0, 26'd0, 1, 32'hFFFF_FFFC, 0, 0);
      step(0, 0, 0, 32'd0, 1, 26'h0000100, 0, 32'd0, 0, 0);

      // jr beats jump and branch; low bits cleared.
      step(0, 0, 1, 32'h0000_1003, 1, 26'h0000100, 1, 32'd8, 0, 0);

      // Stall holds and drops the jump; exception wins over stall.
      go_jr(32'h0000_0020);
      repeat (3) step(1, 0, 0, 32'd0, 1, 26'h0000200, 0, 32'd0, 0, 0);
      step(1, 1, 0, 32'd0, 1, 26'h0000200, 0, 32'd0, 0, 0);

      // Halt, hold, resume, continue.
      go_jr(32'h0000_0100);
      step(0, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1, 0);
      repeat (5) idle();
      step(0, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 1);
      idle();

      // Exception in HALT beats resume.
      step(0, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1, 0);
      step(0, 1, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 1);

      // Wrap at the top of the address space.
      go_jr(32'hFFFF_FFFC);
      idle();

      // Reset pulsed while stalled at a non-reset PC.
      go_jr(32'h0000_0300);
      step(1, 0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 0);
      do_reset();

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5,
              $urandom_range(0, 99) < 15, $urandom(),
              $urandom_range(0, 99) < 15, 26'($urandom()),
              $urandom_range(0, 99) < 20, $urandom(),
              $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30);
      end

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program-counter register for the MIPS core and decides its next value every cycle.
- Sources, in priority order: exception vector, jump-register, jump, taken branch, sequential PC+4.
- Adds a boot wait after reset, a pipeline-stall hold and a halt/resume state machine.
- Feeds the instruction-memory address and the PC+4 value used by the link/branch datapath.

Parameters:
- N_BIT, 32, PC width in bits; must be 32 for the jump-target concatenation.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset and held during boot.
- EXC_VECTOR, 32'h8000_0180, PC loaded on an exception.
- BOOT_CYCLES, 2, cycles spent in BOOT after reset release before the first fetch; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC (hazard or memory wait).
- exception  input  1  redirect to EXC_VECTOR and capture EPC.
- jr  input  1  jump-register request.
- jr_target  input  N_BIT  register-file value for jr.
- jump  input  1  J/JAL request.
- jump_index  input  26  instruction bits [25:0].
- branch_taken  input  1  conditional branch resolved taken.
- branch_offset  input  N_BIT  sign-extended 16-bit immediate, in words.
- halt_req  input  1  SYSCALL/BREAK decoded; enter HALT.
- resume  input  1  leave HALT.
- pc  output  N_BIT  current PC, registered.
- pc_plus4  output  N_BIT  pc + 4, combinational.
- epc  output  N_BIT  PC of the excepting instruction, registered.
- fetch_valid  output  1  high when pc addresses a real instruction (state RUN).
- state  output  2  00 BOOT, 01 RUN, 10 HALT.

Behaviour:
- Reset (asynchronous): pc = RESET_VECTOR, epc = 0, state = BOOT, boot counter = 0, fetch_valid = 0.
- BOOT: pc holds RESET_VECTOR and all request inputs are ignored. The counter increments each cycle; when it reaches BOOT_CYCLES-1, state becomes RUN on the next edge. With BOOT_CYCLES=2, fetch_valid is first high on the 2nd rising edge after reset_n deasserts.
- fetch_valid = (state == RUN), combinational from the state register.
- Arithmetic (all modulo 2^N_BIT, wrap silently):
  - pc_plus4 = pc + 4
  - branch target = pc_plus4 + (branch_offset << 2)
  - jump target = {pc_plus4[31:28], jump_index, 2'b00}
  - jr target = {jr_target[31:2], 2'b00}; low bits are forced to zero, no misalignment trap.
- RUN, next-PC priority, applied at the rising edge:
  1. exception: pc <= EXC_VECTOR, epc <= pc. Takes effect even when stall = 1.
  2. stall: pc holds; jr, jump, branch and halt_req are ignored this cycle.
  3. jr
  4. jump
  5. branch_taken
  6. halt_req: pc <= pc_plus4, state <= HALT.
  7. otherwise pc <= pc_plus4.
- A lower-priority request that is dropped is not remembered. The decoder must re-present it after a stall.
- HALT: pc holds and fetch_valid = 0.
  - resume -> RUN on the next edge, pc unchanged, so execution continues after the halting instruction.
  - exception in HALT -> pc <= EXC_VECTOR, epc <= pc, state <= RUN. This beats resume.
- PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- Reset asserted mid-operation forces the reset values immediately, regardless of state, stall or pending requests.
- State encoding 11 is unreachable; if entered, the next state is BOOT with pc = RESET_VECTOR.

Optional Feature:
- Macro PC_SEQ_PERF_CNT_EN.
- When defined, adds two outputs:
  - retired_cnt (32-bit): increments on every RUN cycle with stall = 0 and exception = 0.
  - stall_cnt (32-bit): increments on every RUN cycle with stall = 1.
- Both counters reset to 0, wrap at 2^32, and hold in BOOT and HALT.
- When not defined, neither port nor counter exists and all other behaviour is identical.

Test Plan:
- Reset release, BOOT_CYCLES=2, no requests -> pc=0 while in BOOT; fetch_valid rises at edge 2; pc then steps 4, 8, 12.
- pc=32'h0000_0040, branch_taken=1, branch_offset=32'hFFFF_FFFC -> next pc=32'h0000_0034. Then jump=1, jump_index=26'h0000100 -> pc=32'h0000_0400.
- Same cycle jr=1, jr_target=32'h0000_1003, jump=1, branch_taken=1 -> pc=32'h0000_1000 (jr wins, low bits cleared).
- pc=32'h0000_0020, stall=1 for 3 cycles with jump asserted -> pc stays 32'h20. Then exception=1 while stall=1 -> pc=32'h8000_0180, epc=32'h20.
- pc=32'h0000_0100, halt_req=1 -> pc=32'h104, state=HALT, fetch_valid=0. pc holds for 5 cycles; resume=1 -> state=RUN, next pc=32'h108.
- pc=32'hFFFF_FFFC, no request -> pc=0. reset_n pulsed low mid-stall -> pc=0 and state=BOOT immediately, without waiting for a clock edge.
